// File: rtl/sim_mem_responder_if.sv
// Host-to-memory req/gnt/rvalid link; the host drives the master modport and the
// memory model implements the slave modport.
interface sim_mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/sim_mem_responder.sv
// Simulation word memory answering req/gnt/rvalid with a fixed response latency.
// Define SIM_MEM_STALL_EN to throttle grants with a pseudo-random LFSR stall.
module sim_mem_responder #(
    parameter int unsigned Depth       = 1024,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned RespLatency = 1,
    parameter logic [7:0]  StallSeed   = 8'hA5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sim_mem_responder_if.slave  bus
);
    localparam int unsigned IdxW   = $clog2(Depth);
    localparam logic [32:0] LoAddr = {1'b0, BaseAddr};
    localparam logic [32:0] HiAddr = LoAddr + (33'(Depth) << 2);

    if (RespLatency < 1 || RespLatency > 4) begin : g_bad_latency
        $fatal(1, "sim_mem_responder: RespLatency must be 1..4");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sim_mem_responder: Depth must be a power of 2 and >= 2");
    end
    if ((BaseAddr % (Depth * 4)) != 0) begin : g_bad_base
        $fatal(1, "sim_mem_responder: BaseAddr must be Depth*4 aligned");
    end
    // An all-zero seed would freeze the LFSR in a permanent stall.
    if (StallSeed == 8'h00) begin : g_bad_seed
        $fatal(1, "sim_mem_responder: StallSeed must be nonzero");
    end

    logic            w_stall;
    logic            w_accept;
    logic            w_in_range;
    logic [IdxW-1:0] w_idx;

    logic [31:0] r_mem [Depth];

    logic [RespLatency-1:0] r_valid;
    logic [RespLatency-1:0] r_err;
    logic [31:0]            r_data [RespLatency];

`ifdef SIM_MEM_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci taps 8,6,5,4 shifted left with feedback into bit 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= StallSeed;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign bus.gnt_o  = bus.req_i & ~w_stall & ~rst_i;
    assign w_accept   = bus.req_i & bus.gnt_o;
    // 33-bit compare keeps BaseAddr + Depth*4 from wrapping at the top of the map.
    assign w_in_range = ({1'b0, bus.addr_i} >= LoAddr) && ({1'b0, bus.addr_i} < HiAddr);
    assign w_idx      = IdxW'((bus.addr_i - BaseAddr) >> 2);

    // NOTE: the array has no reset branch; memory contents survive reset and a reset
    // loop over every word would not map onto a RAM.
    always_ff @(posedge clk_i) begin
        if (w_accept && bus.we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 is loaded at the accept edge; the last stage drives the response port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_err   <= '0;
            r_data  <= '{default: '0};
        end else begin
            r_valid[0] <= w_accept;
            r_err[0]   <= w_accept & ~w_in_range;
            r_data[0]  <= (w_accept && !bus.we_i && w_in_range) ? r_mem[w_idx] : 32'h0;
            for (int i = 1; i < RespLatency; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign bus.rvalid_o = r_valid[RespLatency-1];
    assign bus.err_o    = r_err[RespLatency-1];
    assign bus.rdata_o  = r_data[RespLatency-1];
endmodule

// File: tb/tb_sim_mem_responder.sv
// Directed bench for sim_mem_responder: one instance at latency 1, one at latency 3.
// Response monitors log every rvalid cycle; tests compare the logs to hand-computed values.
module tb_sim_mem_responder;
    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] TOP   = BASE + DEPTH * 4;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ed;
        bit          ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   idle_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sim_mem_responder_if b1 ();
    sim_mem_responder_if b3 ();

    sim_mem_responder #(.Depth(DEPTH), .BaseAddr(BASE), .RespLatency(1), .StallSeed(8'hA5))
        u_l1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    sim_mem_responder #(.Depth(DEPTH), .BaseAddr(BASE), .RespLatency(3), .StallSeed(8'hA5))
        u_l3 (.clk_i(clk), .rst_i(rst), .bus(b3));

    logic [31:0] q1_d[$];
    logic [31:0] q3_d[$];
    bit          q1_e[$];
    bit          q3_e[$];
    int          q1_c[$];
    int          q3_c[$];

    // Reference grant-stall LFSR: seed A5, taps 8,6,5,4, shift left.
    logic [7:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) begin
        if (b1.rvalid_o === 1'b1) begin
            q1_d.push_back(b1.rdata_o);
            q1_e.push_back(b1.err_o);
            q1_c.push_back(cyc);
        end else if (b1.rdata_o !== 32'h0 || b1.err_o !== 1'b0) begin
            idle_bad = idle_bad + 1;
        end
        if (b3.rvalid_o === 1'b1) begin
            q3_d.push_back(b3.rdata_o);
            q3_e.push_back(b3.err_o);
            q3_c.push_back(cyc);
        end else if (b3.rdata_o !== 32'h0 || b3.err_o !== 1'b0) begin
            idle_bad = idle_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        b1.req_i = 1'b0; b1.we_i = 1'b0; b1.addr_i = '0; b1.wdata_i = '0; b1.be_i = '0;
        b3.req_i = 1'b0; b3.we_i = 1'b0; b3.addr_i = '0; b3.wdata_i = '0; b3.be_i = '0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        q1_d.delete(); q1_e.delete(); q1_c.delete();
        q3_d.delete(); q3_e.delete(); q3_c.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge,
    // with acc = index of the accept edge. The request stays driven for chaining.
    task automatic issue(input bit sel3, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, output int acc);
        int  tries;
        bit  g;
        tries = 0;
        if (sel3) begin
            b3.req_i = 1'b1; b3.we_i = we; b3.addr_i = addr; b3.wdata_i = wd; b3.be_i = be;
        end else begin
            b1.req_i = 1'b1; b1.we_i = we; b1.addr_i = addr; b1.wdata_i = wd; b1.be_i = be;
        end
        #1;
        g = sel3 ? b3.gnt_o : b1.gnt_o;
        while (!g && tries < 50) begin
            @(negedge clk); #1;
            g = sel3 ? b3.gnt_o : b1.gnt_o;
            tries++;
        end
        if (!g) begin
            check("grant_timeout", 32'(g), 32'd1);
            acc = -1;
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t4[8];
        int   a;
        int   aw;
        int   ar;
        int   acc[4];
        int   grants;
        bit   exp_g;

        idle();
        #2 rst = 1'b1;
        b1.req_i = 1'b1;
        b3.req_i = 1'b1;
        @(negedge clk); #1;
        check("rst_gnt_l1", 32'(b1.gnt_o), 32'd0);
        check("rst_gnt_l3", 32'(b3.gnt_o), 32'd0);
        check("rst_rvalid_l1", 32'(b1.rvalid_o), 32'd0);
        check("rst_rdata_l1", b1.rdata_o, 32'd0);
        check("rst_err_l1", 32'(b1.err_o), 32'd0);
        check("rst_rvalid_l3", 32'(b3.rvalid_o), 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: reset while a latency-3 read is in flight.
        issue(1'b1, 1'b1, BASE + 8, 32'h1234_5678, 4'hF, a);
        idle(); wait_cyc(6); clear_q();
        issue(1'b1, 1'b0, BASE + 8, 32'h0, 4'h0, a);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("t1_rst_rvalid", 32'(b3.rvalid_o), 32'd0);
        check("t1_rst_rdata", b3.rdata_o, 32'd0);
        check("t1_rst_err", 32'(b3.err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(8);
        check("t1_dropped_cnt", 32'(q3_d.size()), 32'd0);
        issue(1'b1, 1'b0, BASE + 8, 32'h0, 4'h0, a);
        idle(); wait_cyc(6);
        check("t1_reread_cnt", 32'(q3_d.size()), 32'd1);
        if (q3_d.size() >= 1) begin
            check("t1_mem_kept", q3_d[0], 32'h1234_5678);
            check("t1_reread_err", 32'(q3_e[0]), 32'd0);
            check("t1_reread_lat", 32'(q3_c[0]), 32'(a + 2));
        end
        clear_q();

        // Test 2: byte-masked overwrite, latency 1.
        issue(1'b0, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, a);
        issue(1'b0, 1'b1, BASE, 32'h0000_00AA, 4'b0001, a);
        issue(1'b0, 1'b0, BASE, 32'h0, 4'h0, a);
        idle(); wait_cyc(4);
        check("t2_cnt", 32'(q1_d.size()), 32'd3);
        if (q1_d.size() >= 3) begin
            check("t2_wr_rdata", q1_d[0], 32'h0);
            check("t2_wr_err", 32'(q1_e[1]), 32'd0);
            check("t2_rd_data", q1_d[2], 32'hDEAD_BEAA);
            check("t2_rd_err", 32'(q1_e[2]), 32'd0);
            check("t2_rd_lat", 32'(q1_c[2]), 32'(a));
        end
        clear_q();

        // Test 3: four back-to-back reads at latency 3.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b1, BASE + 32'h10 + 32'(4 * i), 32'hA0A0_0000 | 32'(i), 4'hF, a);
        end
        idle(); wait_cyc(6); clear_q();
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, BASE + 32'h10 + 32'(4 * i), 32'h0, 4'h0, acc[i]);
        end
        idle(); wait_cyc(8);
        check("t3_cnt", 32'(q3_d.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (q3_d.size() > i) begin
                check($sformatf("t3_data%0d", i), q3_d[i], 32'hA0A0_0000 | 32'(i));
                check($sformatf("t3_lat%0d", i), 32'(q3_c[i]), 32'(acc[i] + 2));
`ifndef SIM_MEM_STALL_EN
                check($sformatf("t3_consec%0d", i), 32'(q3_c[i]), 32'(acc[0] + 2 + i));
`endif
            end
        end
        clear_q();

        // Test 4: address range boundaries and be=0 writes.
        t4[0] = '{1'b1, TOP - 4,    32'h0BAD_F00D, 4'hF, 32'h0,         1'b0};
        t4[1] = '{1'b0, BASE - 4,   32'h0,         4'h0, 32'h0,         1'b1};
        t4[2] = '{1'b0, TOP,        32'h0,         4'h0, 32'h0,         1'b1};
        t4[3] = '{1'b1, TOP,        32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        t4[4] = '{1'b1, 32'h0,      32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        t4[5] = '{1'b1, BASE,       32'h5555_5555, 4'h0, 32'h0,         1'b0};
        t4[6] = '{1'b0, BASE,       32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
        t4[7] = '{1'b0, TOP - 4,    32'h0,         4'h0, 32'h0BAD_F00D, 1'b0};
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, t4[i].we, t4[i].addr, t4[i].wd, t4[i].be, a);
        end
        idle(); wait_cyc(4);
        check("t4_cnt", 32'(q1_d.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (q1_d.size() > i) begin
                check($sformatf("t4_data%0d", i), q1_d[i], t4[i].ed);
                check($sformatf("t4_err%0d", i), 32'(q1_e[i]), 32'(t4[i].ee));
            end
        end
        clear_q();

        // Test 5: write then read the same word on consecutive edges.
        issue(1'b0, 1'b1, BASE + 12, 32'hCAFE_F00D, 4'hF, aw);
        issue(1'b0, 1'b0, BASE + 12, 32'h0, 4'h0, ar);
        idle(); wait_cyc(4);
        check("t5_cnt", 32'(q1_d.size()), 32'd2);
        if (q1_d.size() >= 2) begin
            check("t5_raw_data", q1_d[1], 32'hCAFE_F00D);
            check("t5_raw_lat", 32'(q1_c[1]), 32'(ar));
        end
        clear_q();

        // Test 6: grant behaviour over 64 cycles against the reference model.
        grants = 0;
        for (int i = 0; i < 64; i++) begin
`ifdef SIM_MEM_STALL_EN
            b1.req_i = 1'b1;
`else
            b1.req_i = ((i % 3) != 0);
`endif
            b1.we_i = 1'b0;
            b1.addr_i = BASE;
            #1;
`ifdef SIM_MEM_STALL_EN
            exp_g = (m_lfsr[1:0] != 2'b00);
`else
            exp_g = b1.req_i;
`endif
            check($sformatf("t6_gnt%0d", i), 32'(b1.gnt_o), 32'(exp_g));
            if (exp_g) grants++;
            @(negedge clk);
        end
        idle(); wait_cyc(4);
        check("t6_resp_count", 32'(q1_d.size()), 32'(grants));
        clear_q();

        check("idle_outputs_zero", 32'(idle_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
